// File: rtl/kolum_mem_pkg.sv
// Shared memory-subsystem definitions.
//   sram_state_e    : SRAM transfer FSM encoding
//   ADDR_OFFSET_DEF : byte address at which the external SRAM window starts
//   SRAM_DATA_W     : external SRAM data bus width (half-word)
package kolum_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } sram_state_e;

   localparam logic [31:0] ADDR_OFFSET_DEF = 32'd1024;
   localparam int          SRAM_DATA_W     = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter timing each half-word SRAM transfer.
//   clk, rst : clock, async active-low reset
//   load     : reload to WAIT_CYCLES-1 (state entry)
//   count    : decrement towards zero
//   done     : terminal count reached (last cycle of the current half)
module sram_wait_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic done
);

   localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

   logic [3:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= RELOAD;
      end else if (count && (cnt_q != 4'd0)) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// 32-bit pipeline load/store to 16-bit external SRAM bridge.
// Each access is split into a low and a high half-word transfer.
//   clk, rst               : clock, async active-low reset
//   mem_read_enable_in     : load request (MEM stage)
//   mem_write_enable_in    : store request (MEM stage), wins over read
//   alu_res_in, val_rm_in  : byte address, store data
//   result_out             : load data, held until the next load completes
//   ready_out              : one-cycle completion pulse
//   freeze_out             : pipeline stall request
//   sram_addr_out          : half-word address
//   sram_wdata_out         : write half-word
//   sram_rdata_in          : read half-word
//   sram_we_n_out          : write strobe, active-low
//   sram_oe_n_out          : output enable, active-low
//
// state | meaning
// IDLE  | waiting for a request; latches address/data/op when one arrives
// LOW   | transferring half-word 0 for WAIT_CYCLES cycles
// HIGH  | transferring half-word 1 for WAIT_CYCLES cycles
// DONE  | one-cycle ready pulse, requests ignored
module sram_controller
   import kolum_mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_OFFSET = ADDR_OFFSET_DEF,
   parameter int          SRAM_ADDR_W = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read_enable_in,
   input  logic                   mem_write_enable_in,
   input  logic [31:0]            alu_res_in,
   input  logic [31:0]            val_rm_in,
   output logic [31:0]            result_out,
   output logic                   ready_out,
   output logic                   freeze_out,
   output logic [SRAM_ADDR_W-1:0] sram_addr_out,
   output logic [SRAM_DATA_W-1:0] sram_wdata_out,
   input  logic [SRAM_DATA_W-1:0] sram_rdata_in,
   output logic                   sram_we_n_out,
   output logic                   sram_oe_n_out
);

   sram_state_e state_q, state_d;

   logic                   req;
   logic                   op_wr_q;
   logic [SRAM_ADDR_W-2:0] addr_q;
   logic [31:0]            data_q;
   logic [15:0]            rd_lo_q;
   logic                   cnt_load, cnt_count, cnt_done;
   logic                   freeze_raw;

   assign req = mem_read_enable_in | mem_write_enable_in;

   sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk   (clk),
      .rst   (rst),
      .load  (cnt_load),
      .count (cnt_count),
      .done  (cnt_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_load       = 1'b0;
      cnt_count      = 1'b0;
      freeze_raw     = 1'b0;
      ready_out      = 1'b0;
      sram_addr_out  = '0;
      sram_wdata_out = '0;
      sram_we_n_out  = 1'b1;
      sram_oe_n_out  = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               freeze_raw = 1'b1;
               cnt_load   = 1'b1;
               state_d    = ST_LOW;
            end
         end
         ST_LOW: begin
            freeze_raw    = 1'b1;
            cnt_count     = 1'b1;
            sram_addr_out = {addr_q, 1'b0};
            if (op_wr_q) begin
               sram_we_n_out  = 1'b0;
               sram_wdata_out = data_q[15:0];
            end else begin
               sram_oe_n_out  = 1'b0;
            end
            if (cnt_done) begin
               cnt_load = 1'b1;
               state_d  = ST_HIGH;
            end
         end
         ST_HIGH: begin
            freeze_raw    = 1'b1;
            cnt_count     = 1'b1;
            sram_addr_out = {addr_q, 1'b1};
            if (op_wr_q) begin
               sram_we_n_out  = 1'b0;
               sram_wdata_out = data_q[31:16];
            end else begin
               sram_oe_n_out  = 1'b0;
            end
            if (cnt_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ready_out = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The state is already IDLE in reset, but a request could still be
   // present on the inputs; the stall must not leak out while in reset.
   assign freeze_out = rst & freeze_raw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_wr_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         rd_lo_q    <= '0;
         result_out <= '0;
      end else begin
         if ((state_q == ST_IDLE) && req) begin
            op_wr_q <= mem_write_enable_in;
            // Subtraction wraps at 32 bits; the cast drops the byte offset
            // and wraps the word index to the SRAM size.
            addr_q  <= (SRAM_ADDR_W-1)'((alu_res_in - ADDR_OFFSET) >> 2);
            data_q  <= val_rm_in;
         end
         if ((state_q == ST_LOW) && cnt_done && !op_wr_q) begin
            rd_lo_q <= sram_rdata_in;
         end
         if ((state_q == ST_HIGH) && cnt_done && !op_wr_q) begin
            result_out <= {sram_rdata_in, rd_lo_q};
         end
      end
   end

endmodule
